rect_fill_fsm: RTL and testbench



---
 rtl/lab_pkg.sv | 16 +
 rtl/rect_fill_fsm_if.sv | 40 ++++
 rtl/xy_scan_counter.sv | 40 ++++
 rtl/rect_fill_fsm.sv | 134 +++++++++++++
 tb/tb_rect_fill_fsm.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lab_pkg.sv
// Shared types and screen defaults for the rectangle fill controller.
// Optional feature macro used by the block: RECT_FILL_ABORT_EN.
package lab_pkg;

   localparam int unsigned SCREEN_W_DEF = 160;
   localparam int unsigned SCREEN_H_DEF = 120;

   typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} e_fill_state;

   typedef enum logic [1:0] {
      MODE_SOLID = 2'd0,
      MODE_COL   = 2'd1,
      MODE_ROW   = 2'd2
   } fill_mode_e;

endpackage

// File: rtl/rect_fill_fsm_if.sv
// Request and plot bus between the lab top level, the fill controller and the VGA adapter.
// RECT_FILL_ABORT_EN adds the abort request line.
interface rect_fill_fsm_if #(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned COLOUR_W = 3
) ();
   logic                start;
   logic [X_W-1:0]      x0;
   logic [Y_W-1:0]      y0;
   logic [X_W:0]        w;
   logic [Y_W:0]        h;
   logic [COLOUR_W-1:0] colour;
   logic [1:0]          mode;
`ifdef RECT_FILL_ABORT_EN
   logic                abort;
`endif
   logic                busy;
   logic                done;
   logic [X_W-1:0]      vga_x;
   logic [Y_W-1:0]      vga_y;
   logic [COLOUR_W-1:0] vga_colour;
   logic                vga_plot;

   modport master (
`ifdef RECT_FILL_ABORT_EN
      output abort,
`endif
      output start, x0, y0, w, h, colour, mode,
      input  busy, done, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
`ifdef RECT_FILL_ABORT_EN
      input  abort,
`endif
      input  start, x0, y0, w, h, colour, mode,
      output busy, done, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/xy_scan_counter.sv
// Row-major x/y scan counter over an inclusive window [x_start..x_end] x [y_start..y_end].
// Unaffected by RECT_FILL_ABORT_EN.
module xy_scan_counter #(
   parameter int unsigned X_W = 8,
   parameter int unsigned Y_W = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic           en,
   input  logic [X_W-1:0] x_start,
   input  logic [Y_W-1:0] y_start,
   input  logic [X_W-1:0] x_end,
   input  logic [Y_W-1:0] y_end,
   output logic [X_W-1:0] x_cnt,
   output logic [Y_W-1:0] y_cnt,
   output logic           last
);

   assign last = (x_cnt == x_end) && (y_cnt == y_end);

   // Counters freeze on the final pixel so y never steps past y_end.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (load) begin
         x_cnt <= x_start;
         y_cnt <= y_start;
      end else if (en && !last) begin
         if (x_cnt == x_end) begin
            x_cnt <= x_start;
            y_cnt <= y_cnt + Y_W'(1);
         end else begin
            x_cnt <= x_cnt + X_W'(1);
         end
      end
   end

endmodule

// File: rtl/rect_fill_fsm.sv
// Clipped rectangle fill controller driving the VGA adapter plot port, one pixel per clock.
// Define RECT_FILL_ABORT_EN to add an abort input that ends a fill early.
module rect_fill_fsm
   import lab_pkg::*;
#(
   parameter int unsigned SCREEN_W = SCREEN_W_DEF,
   parameter int unsigned SCREEN_H = SCREEN_H_DEF,
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned COLOUR_W = 3
) (
   input  logic          clk,
   input  logic          rst,
   rect_fill_fsm_if.slave bus
);

   localparam int unsigned XE_W = X_W + 2;
   localparam int unsigned YE_W = Y_W + 2;

   e_fill_state         state, state_nxt;
   logic [X_W-1:0]      x0_q;
   logic [Y_W-1:0]      y0_q;
   logic [X_W:0]        w_q;
   logic [Y_W:0]        h_q;
   logic [COLOUR_W-1:0] colour_q;
   logic [1:0]          mode_q;

   logic [XE_W-1:0]     x_sum;
   logic [YE_W-1:0]     y_sum;
   logic [X_W-1:0]      x_end;
   logic [Y_W-1:0]      y_end;
   logic                empty;
   logic [X_W-1:0]      x_cnt;
   logic [Y_W-1:0]      y_cnt;
   logic                last;
   logic [COLOUR_W-1:0] pix_colour;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Request capture; the request lines are ignored once a fill is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         colour_q <= '0;
         mode_q   <= '0;
      end else if (state == IDLE && bus.start) begin
         x0_q     <= bus.x0;
         y0_q     <= bus.y0;
         w_q      <= bus.w;
         h_q      <= bus.h;
         colour_q <= bus.colour;
         mode_q   <= bus.mode;
      end
   end

   // Two extra bits keep x0+w-1 from wrapping before it is clipped to the screen.
   assign x_sum = XE_W'(x0_q) + XE_W'(w_q) - XE_W'(1);
   assign y_sum = YE_W'(y0_q) + YE_W'(h_q) - YE_W'(1);
   assign x_end = (x_sum > XE_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : X_W'(x_sum);
   assign y_end = (y_sum > YE_W'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : Y_W'(y_sum);

   assign empty = (w_q == '0) || (h_q == '0) ||
                  ((X_W+1)'(x0_q) >= (X_W+1)'(SCREEN_W)) ||
                  ((Y_W+1)'(y0_q) >= (Y_W+1)'(SCREEN_H));

   xy_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
      .clk     (clk),
      .rst     (rst),
      .load    (state == LOAD),
      .en      (state == DRAW),
      .x_start (x0_q),
      .y_start (y0_q),
      .x_end   (x_end),
      .y_end   (y_end),
      .x_cnt   (x_cnt),
      .y_cnt   (y_cnt),
      .last    (last)
   );

   // Undefined mode 3 falls back to the solid colour.
   always_comb begin
      pix_colour = colour_q;
      case (mode_q)
         MODE_COL: pix_colour = x_cnt[COLOUR_W-1:0];
         MODE_ROW: pix_colour = y_cnt[COLOUR_W-1:0];
         default:  pix_colour = colour_q;
      endcase
   end

   always_comb begin
      state_nxt      = state;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      bus.vga_plot   = 1'b0;
      bus.vga_x      = '0;
      bus.vga_y      = '0;
      bus.vga_colour = '0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = LOAD;
         end
         LOAD: begin
            bus.busy  = 1'b1;
            state_nxt = empty ? DONE : DRAW;
`ifdef RECT_FILL_ABORT_EN
            if (bus.abort) state_nxt = DONE;
`endif
         end
         DRAW: begin
            bus.busy       = 1'b1;
            bus.vga_plot   = 1'b1;
            bus.vga_x      = x_cnt;
            bus.vga_y      = y_cnt;
            bus.vga_colour = pix_colour;
            if (last) state_nxt = DONE;
`ifdef RECT_FILL_ABORT_EN
            if (bus.abort) state_nxt = DONE;
`endif
         end
         DONE: begin
            bus.done = 1'b1;
            if (!bus.start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rect_fill_fsm.sv
// Self-checking bench for rect_fill_fsm: directed table, hand sequences and random fills vs a pixel-list model.
// Covers the abort input when RECT_FILL_ABORT_EN is defined.
module tb_rect_fill_fsm;
   import lab_pkg::*;

   localparam int unsigned X_W = 8;
   localparam int unsigned Y_W = 7;
   localparam int unsigned COLOUR_W = 3;
   localparam int SW = 160;
   localparam int SH = 120;
   localparam int BUDGET = 20000;

   typedef struct {int x; int y; int c;} pix_t;
   typedef struct {int x0; int y0; int w; int h; int colour; int mode; int exp_plots; int exp_done;} vec_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   pix_t exp_q[$];

   always #5 clk = ~clk;

   rect_fill_fsm_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) bus ();

   rect_fill_fsm #(.SCREEN_W(SW), .SCREEN_H(SH), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected pixel stream: clip the rectangle to the screen and walk it row by row.
   task automatic model_fill(input int x0, input int y0, input int w, input int h,
                             input int colour, input int mode, output int n);
      int xe, ye;
      pix_t p;
      exp_q.delete();
      n = 0;
      if (w == 0 || h == 0 || x0 >= SW || y0 >= SH) return;
      xe = (x0 + w - 1 < SW - 1) ? x0 + w - 1 : SW - 1;
      ye = (y0 + h - 1 < SH - 1) ? y0 + h - 1 : SH - 1;
      for (int y = y0; y <= ye; y++)
         for (int x = x0; x <= xe; x++) begin
            p.x = x;
            p.y = y;
            p.c = (mode == 1) ? x % 8 : (mode == 2) ? y % 8 : colour;
            exp_q.push_back(p);
            n++;
         end
   endtask

   task automatic drive_req(input int x0, input int y0, input int w, input int h,
                            input int colour, input int mode);
      bus.x0     = X_W'(x0);
      bus.y0     = Y_W'(y0);
      bus.w      = (X_W+1)'(w);
      bus.h      = (Y_W+1)'(h);
      bus.colour = COLOUR_W'(colour);
      bus.mode   = 2'(mode);
   endtask

   task automatic scramble();
      drive_req($urandom_range(255), $urandom_range(127), $urandom_range(511),
                $urandom_range(255), $urandom_range(7), $urandom_range(3));
   endtask

   task automatic run_fill(input vec_t v, input string tag);
      int n, k, plots, done_k;
      pix_t p;
      model_fill(v.x0, v.y0, v.w, v.h, v.colour, v.mode, n);
      @(negedge clk);
      drive_req(v.x0, v.y0, v.w, v.h, v.colour, v.mode);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      scramble();
      k = 0; plots = 0; done_k = -1;
      while (k < BUDGET) begin
         @(negedge clk);
         k++;
         if (k == 1) chk({tag, "_busy_load"}, int'(bus.busy), 1);
         if (bus.vga_plot) begin
            plots++;
            if (exp_q.size() == 0) chk({tag, "_extra_plot"}, plots, n);
            else begin
               p = exp_q.pop_front();
               chk({tag, "_x"}, int'(bus.vga_x), p.x);
               chk({tag, "_y"}, int'(bus.vga_y), p.y);
               chk({tag, "_colour"}, int'(bus.vga_colour), p.c);
            end
         end else begin
            chk({tag, "_idle_bus"}, int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
         end
         if (bus.done) begin
            done_k = k;
            break;
         end
      end
      chk({tag, "_done_cycle"}, done_k, v.exp_done);
      chk({tag, "_plots"}, plots, v.exp_plots);
      chk({tag, "_missing"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tag, "_idle_done"}, int'(bus.done), 0);
      chk({tag, "_idle_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      vec_t vecs[12];
      vec_t rv;
      int plots, guard, n;

      vecs[0]  = '{0,   0,   160, 120, 0, 1, 19200, 19202}; // full screen, column colour
      vecs[1]  = '{150, 115, 20,  10,  6, 0, 50,    52};    // clipped at both edges
      vecs[2]  = '{10,  10,  0,   5,   3, 0, 0,     2};     // zero width
      vecs[3]  = '{200, 10,  5,   5,   3, 0, 0,     2};     // starts off-screen in x
      vecs[4]  = '{10,  10,  5,   0,   3, 0, 0,     2};     // zero height
      vecs[5]  = '{20,  30,  3,   2,   5, 0, 6,     8};     // solid colour 5
      vecs[6]  = '{0,   100, 4,   25,  1, 2, 80,    82};    // row colour, y clipped
      vecs[7]  = '{5,   5,   2,   2,   2, 3, 4,     6};     // mode 3 acts as solid
      vecs[8]  = '{10,  120, 4,   4,   1, 0, 0,     2};     // starts off-screen in y
      vecs[9]  = '{159, 119, 1,   1,   7, 0, 1,     3};     // bottom-right pixel
      vecs[10] = '{159, 0,   511, 1,   4, 1, 1,     3};     // huge width, no wrap
      vecs[11] = '{0,   0,   1,   1,   4, 0, 1,     3};     // single pixel origin

      rst = 1'b1;
      bus.start = 1'b0;
`ifdef RECT_FILL_ABORT_EN
      bus.abort = 1'b0;
`endif
      drive_req(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_plot", int'(bus.vga_plot), 0);
      chk("rst_x", int'(bus.vga_x), 0);
      chk("rst_y", int'(bus.vga_y), 0);
      chk("rst_colour", int'(bus.vga_colour), 0);
      rst = 1'b0;

      foreach (vecs[i]) run_fill(vecs[i], $sformatf("vec%0d", i));

      // Start held high through and past a 2x2 fill must not restart it.
      @(negedge clk);
      drive_req(7, 8, 2, 2, 0, 1);
      bus.start = 1'b1;
      plots = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.vga_plot) plots++;
      end
      chk("hold_plots", plots, 4);
      chk("hold_done", int'(bus.done), 1);
      bus.start = 1'b0;
      @(negedge clk);
      chk("hold_release_done", int'(bus.done), 0);
      chk("hold_release_busy", int'(bus.busy), 0);

      // Reset after 37 plots of a 10x10 fill, then refill from scratch.
      @(negedge clk);
      drive_req(3, 4, 10, 10, 1, 0);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      plots = 0; guard = 0;
      while (plots < 37 && guard < 200) begin
         @(negedge clk);
         guard++;
         if (bus.vga_plot) plots++;
      end
      chk("midrst_reach", plots, 37);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_plot", int'(bus.vga_plot), 0);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_done", int'(bus.done), 0);
      rst = 1'b0;
      rv = '{3, 4, 10, 10, 1, 0, 100, 102};
      run_fill(rv, "after_rst");

`ifdef RECT_FILL_ABORT_EN
      // Abort raised during the third plot of a 4x4 fill.
      @(negedge clk);
      drive_req(0, 0, 4, 4, 2, 0);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      plots = 0; guard = 0;
      while (plots < 3 && guard < 50) begin
         @(negedge clk);
         guard++;
         if (bus.vga_plot) plots++;
      end
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      if (bus.vga_plot) plots++;
      chk("abort_plots", plots, 3);
      chk("abort_done", int'(bus.done), 1);
      @(negedge clk);
      chk("abort_idle_done", int'(bus.done), 0);
`endif

      for (int r = 0; r < 20; r++) begin
         rv.x0 = $urandom_range(175);
         rv.y0 = $urandom_range(127);
         rv.w = $urandom_range(40);
         rv.h = $urandom_range(30);
         rv.colour = $urandom_range(7);
         rv.mode = $urandom_range(3);
         model_fill(rv.x0, rv.y0, rv.w, rv.h, rv.colour, rv.mode, n);
         rv.exp_plots = n;
         rv.exp_done = n + 2;
         run_fill(rv, $sformatf("rnd%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
